// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared types, constants and the scan-code translation function for the PS/2
// key decoder.
//   state_e        : pop handshake FSM states (IDLE, TAKE, SETTLE)
//   PFX_*          : set-2 prefix bytes (extended, break, pause)
//   CODE_*         : scan codes with side effects (shifts, caps lock)
//   PAUSE_SKIP     : number of bytes swallowed after an E1 prefix
//   scan_to_ascii  : set-2 code + shift + caps -> ASCII (0x00 if unmapped)
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        SETTLE
    } state_e;

    localparam logic [7:0] PFX_EXT     = 8'hE0;
    localparam logic [7:0] PFX_BRK     = 8'hF0;
    localparam logic [7:0] PFX_PAUSE   = 8'hE1;

    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // The pause key sends E1 followed by seven more bytes that carry no
    // key information of their own.
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    // Letters are reduced to an alphabet offset and digits to a value so the
    // case or shift rule is applied once rather than per code.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                                 input logic       shift,
                                                 input logic       caps);
        logic       is_letter;
        logic       is_digit;
        logic [7:0] letter;
        logic [7:0] digit;
        logic [7:0] result;

        is_letter = 1'b1;
        letter    = 8'd0;
        case (code)
            8'h1C: letter = 8'd0;
            8'h32: letter = 8'd1;
            8'h21: letter = 8'd2;
            8'h23: letter = 8'd3;
            8'h24: letter = 8'd4;
            8'h2B: letter = 8'd5;
            8'h34: letter = 8'd6;
            8'h33: letter = 8'd7;
            8'h43: letter = 8'd8;
            8'h3B: letter = 8'd9;
            8'h42: letter = 8'd10;
            8'h4B: letter = 8'd11;
            8'h3A: letter = 8'd12;
            8'h31: letter = 8'd13;
            8'h44: letter = 8'd14;
            8'h4D: letter = 8'd15;
            8'h15: letter = 8'd16;
            8'h2D: letter = 8'd17;
            8'h1B: letter = 8'd18;
            8'h2C: letter = 8'd19;
            8'h3C: letter = 8'd20;
            8'h2A: letter = 8'd21;
            8'h1D: letter = 8'd22;
            8'h22: letter = 8'd23;
            8'h35: letter = 8'd24;
            8'h1A: letter = 8'd25;
            default: is_letter = 1'b0;
        endcase

        is_digit = 1'b1;
        digit    = 8'd0;
        case (code)
            8'h45: digit = 8'd0;
            8'h16: digit = 8'd1;
            8'h1E: digit = 8'd2;
            8'h26: digit = 8'd3;
            8'h25: digit = 8'd4;
            8'h2E: digit = 8'd5;
            8'h36: digit = 8'd6;
            8'h3D: digit = 8'd7;
            8'h3E: digit = 8'd8;
            8'h46: digit = 8'd9;
            default: is_digit = 1'b0;
        endcase

        result = 8'h00;
        if (is_letter) begin
            result = ((shift ^ caps) ? 8'h41 : 8'h61) + letter;
        end else if (is_digit) begin
            // Shifted digits are punctuation, which is not translated.
            result = shift ? 8'h00 : (8'h30 + digit);
        end else begin
            case (code)
                8'h29:   result = 8'h20;
                8'h5A:   result = 8'h0D;
                8'h66:   result = 8'h08;
                8'h76:   result = 8'h1B;
                default: result = 8'h00;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// ps2_ascii_rom
// Combinational scan-code to ASCII map.
//   code  : set-2 scan code without prefixes
//   ext   : code was E0-prefixed (extended keys never translate)
//   shift : shift currently held
//   caps  : caps-lock toggle state
//   ascii : translated character, 0x00 when unmapped
module ps2_ascii_rom
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    assign ascii = ext ? 8'h00 : scan_to_ascii(code, shift, caps);

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Pops PS/2 set-2 bytes from the receiver FIFO, resolves E0/F0/E1 prefixes,
// tracks shift and caps lock, flags typematic repeats and emits one key event
// per complete code.
//   clk, clrn   : clock, asynchronous active-low reset
//   ready, data : receiver FIFO non-empty flag and head byte
//   nextdata_n  : active-low pop strobe, low for exactly the TAKE cycle
//   key_*       : event pulse and fields (held until the next event)
//   ascii       : translation of the event code
//   shift_held  : either shift key currently down
//   caps_lock   : caps-lock toggle
//   keystroke   : count of non-repeat make events (wraps)
module ps2_key_decoder
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_repeat,
    output logic [7:0] ascii,
    output logic       shift_held,
    output logic       caps_lock,
    output logic [7:0] keystroke
);

    state_e     state_q, state_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic [8:0] last_make_q, last_make_d;
    logic       shift_l_q, shift_l_d;
    logic       shift_r_q, shift_r_d;
    logic       caps_q, caps_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic       key_break_q, key_break_d;
    logic       key_repeat_q, key_repeat_d;
    logic [7:0] ascii_q, ascii_d;
    logic [7:0] keystroke_q, keystroke_d;
    logic       take;
    logic [7:0] rom_ascii;
    logic [8:0] code_key;

    // Translation sees the shift/caps state from before this byte updates it.
    ps2_ascii_rom u_rom (
        .code  (data),
        .ext   (ext_q),
        .shift (shift_l_q | shift_r_q),
        .caps  (caps_q),
        .ascii (rom_ascii)
    );

    assign code_key = {ext_q, data};

    // The byte is captured and interpreted on the IDLE->TAKE edge, so the
    // registered event is already visible during TAKE. SETTLE gives the
    // upstream registered ready a cycle to reflect the pop before resampling.
    always_comb begin
        state_d      = state_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        skip_d       = skip_q;
        last_make_d  = last_make_q;
        shift_l_d    = shift_l_q;
        shift_r_d    = shift_r_q;
        caps_d       = caps_q;
        key_valid_d  = 1'b0;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_break_d  = key_break_q;
        key_repeat_d = key_repeat_q;
        ascii_d      = ascii_q;
        keystroke_d  = keystroke_q;
        take         = 1'b0;

        case (state_q)
            IDLE: begin
                if (ready) begin
                    state_d = TAKE;
                    take    = 1'b1;
                end
            end
            TAKE:    state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (take) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (data == PFX_PAUSE) begin
                skip_d = PAUSE_SKIP;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end else if (data == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (data == PFX_BRK) begin
                brk_d = 1'b1;
            end else begin
                key_valid_d  = 1'b1;
                key_code_d   = data;
                key_ext_d    = ext_q;
                key_break_d  = brk_q;
                key_repeat_d = 1'b0;
                ascii_d      = rom_ascii;
                ext_d        = 1'b0;
                brk_d        = 1'b0;
                if (!brk_q) begin
                    if (code_key == last_make_q) begin
                        key_repeat_d = 1'b1;
                    end else begin
                        keystroke_d = keystroke_q + 8'd1;
                        last_make_d = code_key;
                        if (!ext_q && data == CODE_CAPS) begin
                            caps_d = ~caps_q;
                        end
                    end
                    if (!ext_q && data == CODE_LSHIFT) shift_l_d = 1'b1;
                    if (!ext_q && data == CODE_RSHIFT) shift_r_d = 1'b1;
                end else begin
                    if (code_key == last_make_q) begin
                        last_make_d = 9'd0;
                    end
                    if (!ext_q && data == CODE_LSHIFT) shift_l_d = 1'b0;
                    if (!ext_q && data == CODE_RSHIFT) shift_r_d = 1'b0;
                end
            end
        end
    end

    // State and event registers; reset drops the pop strobe immediately.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            skip_q       <= 3'd0;
            last_make_q  <= 9'd0;
            shift_l_q    <= 1'b0;
            shift_r_q    <= 1'b0;
            caps_q       <= 1'b0;
            key_valid_q  <= 1'b0;
            key_code_q   <= 8'd0;
            key_ext_q    <= 1'b0;
            key_break_q  <= 1'b0;
            key_repeat_q <= 1'b0;
            ascii_q      <= 8'd0;
            keystroke_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            skip_q       <= skip_d;
            last_make_q  <= last_make_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            caps_q       <= caps_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_break_q  <= key_break_d;
            key_repeat_q <= key_repeat_d;
            ascii_q      <= ascii_d;
            keystroke_q  <= keystroke_d;
        end
    end

    assign nextdata_n = (state_q != TAKE);
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign key_ext    = key_ext_q;
    assign key_break  = key_break_q;
    assign key_repeat = key_repeat_q;
    assign ascii      = ascii_q;
    assign shift_held = shift_l_q | shift_r_q;
    assign caps_lock  = caps_q;
    assign keystroke  = keystroke_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Self-checking bench for ps2_key_decoder: directed sequences from the key
// decoder's documented behaviour plus randomized byte streams, all compared
// against a keyboard-level reference model.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_repeat;
    logic [7:0] ascii;
    logic       shift_held;
    logic       caps_lock;
    logic [7:0] keystroke;

    ps2_key_decoder dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .nextdata_n (nextdata_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_repeat (key_repeat),
        .ascii      (ascii),
        .shift_held (shift_held),
        .caps_lock  (caps_lock),
        .keystroke  (keystroke)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int events = 0;

    // Pops and event pulses are tallied mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (nextdata_n === 1'b0) pops++;
        if (key_valid === 1'b1) events++;
    end

    // Keyboard-level reference: alphabet and digit key positions on set 2.
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
        8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
        8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h36, 8'h3D, 8'h3E, 8'h46};

    bit         m_ext, m_brk, m_shl, m_shr, m_caps;
    int         m_skip, m_last, m_ks;
    bit         e_valid, e_ext, e_brk, e_rep;
    logic [7:0] e_code, e_ascii;

    function automatic logic [7:0] refAscii(logic [7:0] code, bit ext, bit shift, bit caps);
        if (ext) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) return 8'((shift != caps) ? (65 + i) : (97 + i));
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) return shift ? 8'h00 : 8'(48 + i);
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        if (code == 8'h66) return 8'h08;
        if (code == 8'h76) return 8'h1B;
        return 8'h00;
    endfunction

    task automatic modelReset();
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0;
        m_skip = 0; m_last = 0; m_ks = 0;
        e_valid = 0; e_ext = 0; e_brk = 0; e_rep = 0;
        e_code = 8'h00; e_ascii = 8'h00;
    endtask

    task automatic modelByte(input logic [7:0] b);
        int key;
        e_valid = 0;
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            key     = (m_ext ? 256 : 0) + int'(b);
            e_valid = 1;
            e_code  = b;
            e_ext   = m_ext;
            e_brk   = m_brk;
            e_rep   = 0;
            e_ascii = refAscii(b, m_ext, m_shl || m_shr, m_caps);
            if (!m_brk) begin
                if (key == m_last) begin
                    e_rep = 1;
                end else begin
                    m_ks   = (m_ks + 1) % 256;
                    m_last = key;
                    if (key == 'h58) m_caps = !m_caps;
                end
                if (key == 'h12) m_shl = 1;
                if (key == 'h59) m_shr = 1;
            end else begin
                if (key == m_last) m_last = 0;
                if (key == 'h12) m_shl = 0;
                if (key == 'h59) m_shr = 0;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"},  16'(key_valid),  16'(e_valid));
        checkOutput({tag, ".code"},   16'(key_code),   16'(e_code));
        checkOutput({tag, ".ext"},    16'(key_ext),    16'(e_ext));
        checkOutput({tag, ".break"},  16'(key_break),  16'(e_brk));
        checkOutput({tag, ".repeat"}, 16'(key_repeat), 16'(e_rep));
        checkOutput({tag, ".ascii"},  16'(ascii),      16'(e_ascii));
        checkOutput({tag, ".shift"},  16'(shift_held), 16'(m_shl || m_shr));
        checkOutput({tag, ".caps"},   16'(caps_lock),  16'(m_caps));
        checkOutput({tag, ".ks"},     16'(keystroke),  16'(m_ks));
    endtask

    // Presents one byte as the FIFO head. ready stays high through SETTLE, as
    // the registered upstream flag would, and only refreshes after SETTLE.
    task automatic applyStimulus(input logic [7:0] b);
        bit got;
        got = 0;
        @(negedge clk);
        ready = 1'b1;
        data  = b;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (nextdata_n === 1'b0) begin
                got = 1;
                break;
            end
        end
        checkOutput("pop_seen", 16'(got), 16'd1);
        modelByte(b);
        if (got) checkAll("take");
        @(negedge clk);
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        clrn  = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        modelReset();
    endtask

    logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h32,
                              8'h21, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h75};

    initial begin
        int p0, ev0;
        logic [7:0] b;
        modelReset();

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_nextdata_n", 16'(nextdata_n), 16'd1);
        checkAll("rst");
        clrn = 1'b1;

        // Plain make/break of 'a'
        p0 = pops;
        applyStimulus(8'h1C);
        checkOutput("a_code", 16'(key_code), 16'h1C);
        checkOutput("a_ascii", 16'(ascii), 16'h61);
        checkOutput("a_ks", 16'(keystroke), 16'd1);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        checkOutput("a_break", 16'(key_break), 16'd1);
        checkOutput("a_break_ks", 16'(keystroke), 16'd1);
        checkOutput("a_pops", 16'(pops - p0), 16'd3);

        // Shifted letter
        applyStimulus(8'h12);
        checkOutput("sh_held", 16'(shift_held), 16'd1);
        applyStimulus(8'h1C);
        checkOutput("sh_ascii", 16'(ascii), 16'h41);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        checkOutput("sh_still", 16'(shift_held), 16'd1);
        applyStimulus(8'hF0);
        applyStimulus(8'h12);
        checkOutput("sh_release", 16'(shift_held), 16'd0);

        // Caps lock
        applyStimulus(8'h58);
        checkOutput("caps_on", 16'(caps_lock), 16'd1);
        applyStimulus(8'hF0);
        applyStimulus(8'h58);
        applyStimulus(8'h1C);
        checkOutput("caps_ascii", 16'(ascii), 16'h41);

        // Typematic repeat from a fresh start
        doReset();
        applyStimulus(8'h1C);
        checkOutput("rep0", 16'(key_repeat), 16'd0);
        applyStimulus(8'h1C);
        checkOutput("rep1", 16'(key_repeat), 16'd1);
        applyStimulus(8'h1C);
        checkOutput("rep2", 16'(key_repeat), 16'd1);
        checkOutput("rep_ks", 16'(keystroke), 16'd1);

        // Extended keys and the pause sequence
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        checkOutput("ext_make", 16'(key_ext), 16'd1);
        checkOutput("ext_ascii", 16'(ascii), 16'h00);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        checkOutput("ext_brk", 16'({key_ext, key_break}), 16'd3);
        p0  = pops;
        ev0 = events;
        foreach (pool[i]) if (i < 0) b = pool[i];
        applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77);
        applyStimulus(8'hE1); applyStimulus(8'hF0); applyStimulus(8'h14);
        applyStimulus(8'hF0); applyStimulus(8'h77);
        checkOutput("pause_pops", 16'(pops - p0), 16'd8);
        checkOutput("pause_events", 16'(events - ev0), 16'd0);

        // Asynchronous reset landing inside TAKE
        @(negedge clk);
        ready = 1'b1;
        data  = 8'h1C;
        @(posedge clk);
        #1;
        checkOutput("midtake_in", 16'(nextdata_n), 16'd0);
        clrn = 1'b0;
        #1;
        checkOutput("midtake_ndn", 16'(nextdata_n), 16'd1);
        checkOutput("midtake_valid", 16'(key_valid), 16'd0);
        checkOutput("midtake_ks", 16'(keystroke), 16'd0);
        ready = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        modelReset();

        // 256 distinct makes wrap the keystroke counter
        for (int i = 0; i < 256; i++) applyStimulus((i % 2 == 0) ? 8'h1C : 8'h32);
        checkOutput("ks_wrap", 16'(keystroke), 16'd0);

        // Randomized byte stream
        doReset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 15)];
            if (b == 8'hE1 && $urandom_range(0, 3) != 0) b = 8'h1C;
            applyStimulus(b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
